led_note_afterglow: RTL

//  Parametrised, registered successor of the piano note/octave LED driver. Splits the

---
 rtl/led_note_afterglow.sv | 124 ++++++++++++
 1 files changed

// File: rtl/led_note_afterglow.sv
// led_note_afterglow: registered note/octave LED driver with per-note afterglow.
// The note bus splits into note LEDs (upper bits) and octave LEDs (lower bits).
// After a key is released each note can keep glowing (HOLD), fade out with a
// coarse PWM (FADE) or blink (BLINK) for HOLD_CYCLES clocks. Every output is a
// flop, so pins change one clock after the bus/mode sample.
module led_note_afterglow #(
   parameter int NOTES       = 7,
   parameter int OCT_W       = 3,
   parameter int HOLD_CYCLES = 4,
   parameter int PWM_BITS    = 2,
   parameter int BLINK_DIV   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NOTES+OCT_W-1:0] Busline,
   input  logic [1:0]             mode,
   output logic [NOTES-1:0]       lednote,
   output logic [OCT_W-1:0]       HighLow,
   output logic                   active
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_HOLD   = 2'b01,
      MODE_FADE   = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_t;

   mode_t mode_sel;
   assign mode_sel = mode_t'(mode);

   logic [NOTES-1:0] note;
   logic [OCT_W-1:0] octave;
   assign note   = Busline[NOTES+OCT_W-1:OCT_W];
   assign octave = Busline[OCT_W-1:0];

   // Afterglow state: one down-counter per note plus shared PWM and blink timers.
   logic [CNT_W-1:0]    cnt     [NOTES];
   logic [CNT_W-1:0]    cnt_nxt [NOTES];
   logic [PWM_BITS-1:0] pwm;
   logic [DIV_W-1:0]    blink_div;
   logic                blink_phase;

   logic [NOTES-1:0] glow;
   logic [NOTES-1:0] fade_on;
   logic [NOTES-1:0] led_nxt;
   logic [OCT_W-1:0] hl_nxt;

   // Per-channel glow, fade comparison and counter reload/decay (pre-update cnt).
   always_comb begin
      glow    = '0;
      fade_on = '0;
      for (int i = 0; i < NOTES; i++) begin
         cnt_nxt[i] = cnt[i];
         glow[i]    = note[i] | (cnt[i] != '0);
         // Duty is the top PWM_BITS of the counter, so the glow dims as it decays.
         fade_on[i] = note[i] | (pwm < cnt[i][CNT_W-1 -: PWM_BITS]);
         if (note[i])
            cnt_nxt[i] = CNT_LOAD;
         else if (cnt[i] != '0)
            cnt_nxt[i] = cnt[i] - CNT_W'(1);
         else
            cnt_nxt[i] = '0;
      end
   end

   // Next LED / octave values selected by display mode.
   always_comb begin
      led_nxt = '0;
      hl_nxt  = '0;
      case (mode_sel)
         MODE_DIRECT: led_nxt = note;
         MODE_HOLD:   led_nxt = glow;
         MODE_FADE:   led_nxt = fade_on;
         MODE_BLINK:  led_nxt = glow & {NOTES{blink_phase}};
         default:     led_nxt = note;
      endcase
      // Octave LEDs follow the bus directly, or latch the newest octave while glowing.
      if (mode_sel == MODE_DIRECT || (|note))
         hl_nxt = octave;
      else if (|glow)
         hl_nxt = HighLow;
      else
         hl_nxt = '0;
   end

   // Counters run in every mode so a mode switch never cuts an afterglow short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NOTES; i++) cnt[i] <= '0;
         pwm         <= '0;
         blink_div   <= '0;
         blink_phase <= 1'b1;
      end else begin
         for (int i = 0; i < NOTES; i++) cnt[i] <= cnt_nxt[i];
         pwm <= pwm + PWM_BITS'(1);
         if (blink_div == DIV_LAST) begin
            blink_div   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_div <= blink_div + DIV_W'(1);
         end
      end
   end

   // Output registers driving the board pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lednote <= '0;
         HighLow <= '0;
         active  <= 1'b0;
      end else begin
         lednote <= led_nxt;
         HighLow <= hl_nxt;
         active  <= |led_nxt;
      end
   end

endmodule
